period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter COUNT_W, default 32: width of period_o and unit counter, range 8..32.
REQ-002 Parameter PRESCALE, default 100: clk_i cycles per measurement unit, range 1..2^16.
REQ-003 Parameter AVG_LOG2, default 0: number of periods averaged is 2^AVG_LOG2, range 0..4.
REQ-004 Parameter TIMEOUT_UNITS, default 2^20: unit count since last accepted event that triggers timeout.
REQ-005 clk_i  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset_ni  input  1: asynchronous, active-low reset.
REQ-007 sig_i  input  1: asynchronous signal under measurement.
REQ-008 start_i  input  1: one-cycle request to begin a measurement.
REQ-009 period_o  output  COUNT_W: averaged period in units, held until next result.
REQ-010 done_o  output  1: one-cycle pulse when period_o, overflow_o and timeout_o are updated.
REQ-011 busy_o  output  1: high in every state except IDLE.
REQ-012 overflow_o  output  1: last result saturated.
REQ-013 timeout_o  output  1: last measurement aborted by timeout.

Function
REQ-014 sig_i SHALL pass a 2-flop synchronizer followed by rising-edge detection, producing a one-cycle edge pulse.
REQ-015 States SHALL be IDLE, ARM, MEASURE, DONE.
REQ-016 IDLE: start_i high -> ARM; start_i SHALL be ignored in all other states.
REQ-017 ARM: on edge pulse -> MEASURE, clearing prescaler, accumulator, periods-seen counter and watchdog.
REQ-018 MEASURE: prescaler counts 0..PRESCALE-1 and wraps; each wrap increments accumulator (COUNT_W+AVG_LOG2 bits) and watchdog.
REQ-019 Accumulator SHALL saturate at all-ones and set an internal sticky overflow flag; it SHALL never wrap.
REQ-020 MEASURE: on edge pulse, periods-seen increments and watchdog clears; when periods-seen reaches 2^AVG_LOG2 -> DONE.
REQ-021 A prescaler wrap and edge pulse in the same cycle SHALL both take effect, the unit increment included in the accumulator.
REQ-022 DONE (one cycle): period_o <= accumulator >> AVG_LOG2, saturated to COUNT_W bits; overflow_o <= sticky flag; timeout_o <= 0; done_o = 1; -> IDLE.
REQ-023 Entering ARM SHALL clear the sticky overflow flag; overflow_o and timeout_o SHALL change only in DONE.
REQ-024 With PRESCALE=1 and AVG_LOG2=0 a signal period of P clk_i cycles SHALL yield period_o = P.
REQ-025 done_o SHALL be asserted exactly one cycle after the final edge pulse is seen.

Reset
REQ-026 Asserting reset_ni SHALL force IDLE and clear all counters, synchronizer flops, period_o, done_o, busy_o, overflow_o and timeout_o to 0.
REQ-027 Reset asserted mid-measurement SHALL abandon it without a done_o pulse; period_o SHALL read 0 afterwards.

Configuration
REQ-028 Macro PERIOD_METER_TIMEOUT_EN defined: watchdog counts units in ARM and MEASURE; reaching TIMEOUT_UNITS -> DONE with period_o=0, overflow_o=0, timeout_o=1.
REQ-029 Macro PERIOD_METER_TIMEOUT_EN undefined: watchdog logic SHALL be absent, timeout_o tied 0, ARM/MEASURE wait indefinitely.

Structure
REQ-030 Package period_meter_pkg SHALL hold the state enum and constants AVG_LOG2_MAX=4 and SYNC_STAGES=2.
REQ-031 Sub-module edge_sync SHALL implement the synchronizer and rising-edge pulse; all other logic SHALL reside in period_meter.

Verification
REQ-032 PRESCALE=10, sig_i period 1000 clk, start_i pulse -> period_o=100, done_o one pulse, overflow_o=0.
REQ-033 AVG_LOG2=2, PRESCALE=1, periods 990,1000,1010,1000 clk -> period_o=1000 after fourth period.
REQ-034 COUNT_W=8, PRESCALE=1, sig_i period 300 clk -> period_o=255, overflow_o=1; next measurement at 100 clk -> overflow_o=0.
REQ-035 start_i pulsed while busy_o=1 -> ignored, single done_o, result unchanged from unperturbed run.
REQ-036 reset_ni low during MEASURE -> no done_o, busy_o=0, period_o=0; subsequent start measures correctly.
REQ-037 Macro defined, TIMEOUT_UNITS=50, PRESCALE=1, sig_i static -> done_o 51 cycles after entering ARM, timeout_o=1, period_o=0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared state encoding and constants for the period meter.
package period_meter_pkg;

    localparam int AVG_LOG2_MAX = 4;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse on each
// rising edge of the synchronized signal.
module edge_sync
    import period_meter_pkg::*;
(
    input  logic clk_i,
    input  logic reset_ni,
    input  logic sig_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the averaged period of sig_i in prescaled clock units.
// Define PERIOD_METER_TIMEOUT_EN to build the watchdog timeout.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNT_W       = 32,
    parameter int PRESCALE      = 100,
    parameter int AVG_LOG2      = 0,
    parameter int TIMEOUT_UNITS = 1 << 20
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               sig_i,
    input  logic               start_i,
    output logic [COUNT_W-1:0] period_o,
    output logic               done_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic               timeout_o
);

    localparam int ACC_W  = COUNT_W + AVG_LOG2;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SEEN_W = AVG_LOG2_MAX + 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [SEEN_W-1:0] AVG_N   = SEEN_W'(1 << AVG_LOG2);

    if (COUNT_W < 8 || COUNT_W > 32 || PRESCALE < 1 || PRESCALE > 65536 ||
        AVG_LOG2 < 0 || AVG_LOG2 > AVG_LOG2_MAX || TIMEOUT_UNITS < 1)
    begin : g_bad_param
        $error("period_meter: parameter out of range");
    end

    state_t              state_q, state_d;
    logic                edge_p;
    logic                active;
    logic                wrap;
    logic                acc_sat;
    logic                last_edge;
    logic                res_ld;
    logic                to_ld;
    logic                timeout_hit;
    logic [PS_W-1:0]     pre_q;
    logic [ACC_W-1:0]    acc_q, acc_inc;
    logic [SEEN_W-1:0]   seen_q, seen_inc;
    logic                ovf_q, ovf_inc;

    edge_sync u_sync (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .sig_i    (sig_i),
        .edge_o   (edge_p)
    );

    assign active    = (state_q == S_ARM) || (state_q == S_MEASURE);
    assign wrap      = active && (pre_q == PS_LAST);
    assign acc_sat   = &acc_q;
    assign acc_inc   = (wrap && !acc_sat) ? acc_q + ACC_W'(1) : acc_q;
    assign ovf_inc   = ovf_q | (wrap & acc_sat);
    assign seen_inc  = seen_q + SEEN_W'(1);
    assign last_edge = edge_p && (seen_inc == AVG_N);
    assign busy_o    = (state_q != S_IDLE);

`ifdef PERIOD_METER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_UNITS + 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    assign timeout_hit = (wd_q == WD_W'(TIMEOUT_UNITS));
    assign timeout_o   = timeout_q;

    // Any accepted edge restarts the watchdog window.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (res_ld)
                timeout_q <= 1'b0;
            else if (to_ld)
                timeout_q <= 1'b1;
            if (state_q == S_IDLE || edge_p)
                wd_q <= '0;
            else if (wrap)
                wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        res_ld  = 1'b0;
        to_ld   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i)
                    state_d = S_ARM;
            end
            S_ARM: begin
                if (edge_p) begin
                    state_d = S_MEASURE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    to_ld   = 1'b1;
                end
            end
            S_MEASURE: begin
                if (last_edge) begin
                    state_d = S_DONE;
                    res_ld  = 1'b1;
                end else if (timeout_hit && !edge_p) begin
                    state_d = S_DONE;
                    to_ld   = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Results load on the edge into DONE so they are valid with done_o.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            acc_q      <= '0;
            seen_q     <= '0;
            ovf_q      <= 1'b0;
            period_o   <= '0;
            overflow_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_o  <= res_ld | to_ld;
            if (!active || wrap || (state_q == S_ARM && edge_p))
                pre_q <= '0;
            else
                pre_q <= pre_q + PS_W'(1);
            if (state_q == S_IDLE || (state_q == S_ARM && edge_p)) begin
                acc_q  <= '0;
                seen_q <= '0;
                ovf_q  <= 1'b0;
            end else if (state_q == S_MEASURE) begin
                acc_q <= acc_inc;
                ovf_q <= ovf_inc;
                if (edge_p)
                    seen_q <= seen_inc;
            end
            if (res_ld) begin
                period_o   <= acc_inc[ACC_W-1:AVG_LOG2];
                overflow_o <= ovf_inc;
            end else if (to_ld) begin
                period_o   <= '0;
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Randomised self-checking bench for period_meter: several parameter sets
// checked against an arithmetic model of the averaged period.
`timescale 1ns/1ps
module tb_period_meter;

`ifdef PERIOD_METER_TIMEOUT_EN
    localparam int NI = 4;
`else
    localparam int NI = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig [NI];
    logic start [NI];
    wire  done_w [NI];
    wire  busy_w [NI];
    wire  ovf_w [NI];
    wire  to_w [NI];
    wire  [31:0] per_w [NI];
    wire  [7:0] per_c;
    int   done_cnt [NI];
    int   pq [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    period_meter #(.COUNT_W(32), .PRESCALE(10), .AVG_LOG2(0)) u_a (
        .clk_i(clk), .reset_ni(rst_n), .sig_i(sig[0]), .start_i(start[0]),
        .period_o(per_w[0]), .done_o(done_w[0]), .busy_o(busy_w[0]),
        .overflow_o(ovf_w[0]), .timeout_o(to_w[0]));

    period_meter #(.COUNT_W(32), .PRESCALE(1), .AVG_LOG2(2)) u_b (
        .clk_i(clk), .reset_ni(rst_n), .sig_i(sig[1]), .start_i(start[1]),
        .period_o(per_w[1]), .done_o(done_w[1]), .busy_o(busy_w[1]),
        .overflow_o(ovf_w[1]), .timeout_o(to_w[1]));

    period_meter #(.COUNT_W(8), .PRESCALE(1), .AVG_LOG2(0)) u_c (
        .clk_i(clk), .reset_ni(rst_n), .sig_i(sig[2]), .start_i(start[2]),
        .period_o(per_c), .done_o(done_w[2]), .busy_o(busy_w[2]),
        .overflow_o(ovf_w[2]), .timeout_o(to_w[2]));
    assign per_w[2] = {24'd0, per_c};

`ifdef PERIOD_METER_TIMEOUT_EN
    wire [15:0] per_d;
    period_meter #(.COUNT_W(16), .PRESCALE(1), .AVG_LOG2(0),
                   .TIMEOUT_UNITS(50)) u_d (
        .clk_i(clk), .reset_ni(rst_n), .sig_i(sig[3]), .start_i(start[3]),
        .period_o(per_d), .done_o(done_w[3]), .busy_o(busy_w[3]),
        .overflow_o(ovf_w[3]), .timeout_o(to_w[3]));
    assign per_w[3] = {16'd0, per_d};
`endif

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++)
            if (done_w[i] === 1'b1) done_cnt[i]++;
    end

    function automatic int cfg_w(input int i);
        case (i)
            2: return 8;
            3: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        return (i == 0) ? 10 : 1;
    endfunction

    function automatic int cfg_a(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    // One measurement over the periods in pq; expectations come from
    // total elapsed clocks / prescale, saturated, then divided by 2^avg.
    task automatic measure(input int idx, input bit poke, input string name);
        longint total, units, maxv, sat;
        logic [31:0] exp_p;
        logic exp_o, got;
        int h, lat, d0, w, s, a;
        w = cfg_w(idx);
        s = cfg_s(idx);
        a = cfg_a(idx);
        total = 0;
        foreach (pq[k]) total += pq[k];
        units = total / s;
        maxv = (longint'(1) << (w + a)) - 1;
        sat = (units > maxv) ? maxv : units;
        exp_p = 32'(sat >> a);
        exp_o = (units > maxv);
        d0 = done_cnt[idx];
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        checks++;
        if (busy_w[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b want 1", name, busy_w[idx]);
        end
        repeat (3) @(negedge clk);
        sig[idx] = 1'b1;
        foreach (pq[k]) begin
            h = pq[k] / 2;
            repeat (h) @(negedge clk);
            sig[idx] = 1'b0;
            if (poke && k == 0) begin
                start[idx] = 1'b1;
                @(negedge clk);
                start[idx] = 1'b0;
                repeat (pq[k] - h - 1) @(negedge clk);
            end else begin
                repeat (pq[k] - h) @(negedge clk);
            end
            sig[idx] = 1'b1;
        end
        got = 1'b0;
        lat = 0;
        while (!got && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            got = (done_w[idx] === 1'b1);
        end
        checks++;
        if (!got || lat != 3) begin
            errors++;
            $display("FAIL %s done latency: got %0d (seen %b) want 3", name, lat, got);
        end
        checks++;
        if (per_w[idx] !== exp_p) begin
            errors++;
            $display("FAIL %s period: got %0d want %0d", name, per_w[idx], exp_p);
        end
        checks++;
        if (ovf_w[idx] !== exp_o) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", name, ovf_w[idx], exp_o);
        end
        checks++;
        if (to_w[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: got %b want 0", name, to_w[idx]);
        end
        @(negedge clk);
        sig[idx] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (done_cnt[idx] - d0 != 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d want 1", name, done_cnt[idx] - d0);
        end
        checks++;
        if (busy_w[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle busy: got %b want 0", name, busy_w[idx]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({busy_w[i], done_w[i], ovf_w[i], to_w[i]} !== 4'b0000 ||
                per_w[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got busy/done/ovf/to %b%b%b%b period %0d want 0",
                         i, busy_w[i], done_w[i], ovf_w[i], to_w[i], per_w[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known();
        pq = '{1000};
        measure(0, 1'b0, "prescale10");
        pq = '{990, 1000, 1010, 1000};
        measure(1, 1'b0, "average4");
        pq = '{300};
        measure(2, 1'b0, "saturate");
        pq = '{100};
        measure(2, 1'b0, "after_saturate");
    endtask

    task automatic test_start_ignored();
        pq = '{1000};
        measure(0, 1'b1, "start_busy");
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt[1];
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        sig[1] = 1'b1;
        repeat (100) @(negedge clk);
        sig[1] = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_w[1] !== 1'b0 || per_w[1] !== 32'd0 || done_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy %b period %0d done %b want 0 0 0",
                     busy_w[1], per_w[1], done_w[1]);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt[1] != d0) begin
            errors++;
            $display("FAIL reset_mid pulses: got %0d want 0", done_cnt[1] - d0);
        end
        pq = '{400, 410, 390, 400};
        measure(1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int idx, n, lo, hi;
        for (int it = 0; it < 8; it++) begin
            idx = $urandom_range(2, 0);
            n = (idx == 1) ? 4 : 1;
            lo = 8;
            hi = (idx == 0) ? 3000 : (idx == 1 ? 700 : 400);
            pq.delete();
            for (int k = 0; k < n; k++) pq.push_back($urandom_range(hi, lo));
            measure(idx, 1'b0, $sformatf("random%0d", it));
        end
    endtask

`ifdef PERIOD_METER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        logic got;
        start[3] = 1'b1;
        @(posedge clk);
        #1;
        start[3] = 1'b0;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            got = (done_w[3] === 1'b1);
        end
        checks++;
        if (!got || lat != 51) begin
            errors++;
            $display("FAIL timeout latency: got %0d (seen %b) want 51", lat, got);
        end
        checks++;
        if (to_w[3] !== 1'b1 || per_w[3] !== 32'd0 || ovf_w[3] !== 1'b0) begin
            errors++;
            $display("FAIL timeout result: got to %b period %0d ovf %b want 1 0 0",
                     to_w[3], per_w[3], ovf_w[3]);
        end
        repeat (4) @(negedge clk);
        pq = '{30};
        measure(3, 1'b0, "after_timeout");
    endtask
`endif

    initial begin
        for (int i = 0; i < NI; i++) begin
            sig[i] = 1'b0;
            start[i] = 1'b0;
        end
        test_reset();
        test_known();
        test_start_ignored();
        test_reset_mid();
        test_random();
`ifdef PERIOD_METER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
